// File: rtl/vga_scan_pkg.sv
`default_nettype none
// ============================================================================
//  vga_scan_pkg
//  Shared 640x480@60 raster timing defaults and types for the VGA scan path.
//  Revision: 1.0
// ============================================================================
package vga_scan_pkg;

    localparam int c_coord_w       = 10;
    localparam int c_chan_w        = 10;

    localparam int c_def_clk_div   = 2;
    localparam int c_def_h_active  = 640;
    localparam int c_def_h_fp      = 16;
    localparam int c_def_h_sync    = 96;
    localparam int c_def_h_bp      = 48;
    localparam int c_def_v_active  = 480;
    localparam int c_def_v_fp      = 10;
    localparam int c_def_v_sync    = 2;
    localparam int c_def_v_bp      = 33;

    typedef struct packed {
        logic [c_chan_w-1:0] r;
        logic [c_chan_w-1:0] g;
        logic [c_chan_w-1:0] b;
    } rgb_t;

    function automatic int scan_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int c_def_h_total = scan_total(c_def_h_active, c_def_h_fp,
                                              c_def_h_sync, c_def_h_bp);
    localparam int c_def_v_total = scan_total(c_def_v_active, c_def_v_fp,
                                              c_def_v_sync, c_def_v_bp);

endpackage
`default_nettype wire

// File: rtl/vga_scan_counter.sv
`default_nettype none
// ============================================================================
//  scan_counter
//  Enabled wrap counter 0..MAX with synchronous reset and terminal-count flag.
//  Revision: 1.0
// ============================================================================
module scan_counter
    import vga_scan_pkg::*;
#(
    parameter int WIDTH = c_coord_w,
    parameter int MAX   = c_def_h_total - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_max) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/vga_scan.sv
`default_nettype none
// ============================================================================
//  vga_scan
//  VGA raster timing generator and registered DAC output stage.
//  Optional macro VGA_BORDER_EN forces a full-white frame around the active area.
//  Revision: 1.0
// ============================================================================
module vga_scan
    import vga_scan_pkg::*;
#(
    parameter int CLK_DIV  = c_def_clk_div,
    parameter int H_ACTIVE = c_def_h_active,
    parameter int H_FP     = c_def_h_fp,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BP     = c_def_h_bp,
    parameter int V_ACTIVE = c_def_v_active,
    parameter int V_FP     = c_def_v_fp,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BP     = c_def_v_bp
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [c_coord_w-1:0] x,
    output logic [c_coord_w-1:0] y,
    input  logic [c_chan_w-1:0]  r,
    input  logic [c_chan_w-1:0]  g,
    input  logic [c_chan_w-1:0]  b,
    output logic [c_chan_w-1:0]  vga_r,
    output logic [c_chan_w-1:0]  vga_g,
    output logic [c_chan_w-1:0]  vga_b,
    output logic                 vga_hs_n,
    output logic                 vga_vs_n,
    output logic                 vga_blank_n,
    output logic                 vga_clk,
    output logic                 frame_start
);

    localparam int c_h_total = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_div_w   = $clog2(CLK_DIV);

    localparam logic [c_div_w-1:0]   c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0]   c_div_half = c_div_w'(CLK_DIV / 2);
    localparam logic [c_coord_w-1:0] c_h_act    = c_coord_w'(H_ACTIVE);
    localparam logic [c_coord_w-1:0] c_hs_beg   = c_coord_w'(H_ACTIVE + H_FP);
    localparam logic [c_coord_w-1:0] c_hs_end   = c_coord_w'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_coord_w-1:0] c_v_act    = c_coord_w'(V_ACTIVE);
    localparam logic [c_coord_w-1:0] c_vs_beg   = c_coord_w'(V_ACTIVE + V_FP);
    localparam logic [c_coord_w-1:0] c_vs_end   = c_coord_w'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_div_w-1:0]   r_div;
    logic                 r_vga_clk;
    logic                 r_hs_n;
    logic                 r_vs_n;
    logic                 r_blank_n;
    logic                 r_frame_start;
    rgb_t                 r_rgb;

    logic                 w_tick;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic                 w_active;
    logic [c_coord_w-1:0] w_hc;
    logic [c_coord_w-1:0] w_vc;
    rgb_t                 w_rgb;

    assign w_tick = (r_div == c_div_last);

    scan_counter #(
        .WIDTH (c_coord_w),
        .MAX   (c_h_total - 1)
    ) u_hc (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_tick),
        .o_count (w_hc),
        .o_wrap  (w_h_wrap)
    );

    scan_counter #(
        .WIDTH (c_coord_w),
        .MAX   (c_v_total - 1)
    ) u_vc (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_tick & w_h_wrap),
        .o_count (w_vc),
        .o_wrap  (w_v_wrap)
    );

    assign w_active = (w_hc < c_h_act) && (w_vc < c_v_act);

`ifdef VGA_BORDER_EN
    localparam logic [c_coord_w-1:0] c_h_last = c_coord_w'(H_ACTIVE - 1);
    localparam logic [c_coord_w-1:0] c_v_last = c_coord_w'(V_ACTIVE - 1);
    logic w_border;
    // Only reached through w_active, so porch pixels on row/column 0 stay black.
    assign w_border = (w_hc == '0) || (w_hc == c_h_last) ||
                      (w_vc == '0) || (w_vc == c_v_last);
    assign w_rgb    = w_border ? '1 : rgb_t'({r, g, b});
`else
    assign w_rgb    = rgb_t'({r, g, b});
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div         <= '0;
            r_vga_clk     <= 1'b0;
            r_rgb         <= '0;
            r_hs_n        <= 1'b1;
            r_vs_n        <= 1'b1;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + 1'b1;
            r_vga_clk     <= (r_div >= c_div_half);
            // Fires in the clock where the counters land on (0,0).
            r_frame_start <= w_tick & w_h_wrap & w_v_wrap;
            if (w_tick) begin
                r_rgb     <= w_active ? w_rgb : '0;
                r_hs_n    <= !((w_hc >= c_hs_beg) && (w_hc < c_hs_end));
                r_vs_n    <= !((w_vc >= c_vs_beg) && (w_vc < c_vs_end));
                r_blank_n <= w_active;
            end
        end
    end

    assign x           = w_hc;
    assign y           = w_vc;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;
    assign vga_hs_n    = r_hs_n;
    assign vga_vs_n    = r_vs_n;
    assign vga_blank_n = r_blank_n;
    assign vga_clk     = r_vga_clk;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
